// File: rtl/keep_one_in_n_unzip_pkg.sv
// Shared definitions for the keep_one_in_n_unzip symbol expander.
// Holds the symbol geometry, the number of dropped LSBs, the rounding fill
// value, the holding-register layout and the phase-to-symbol selector.
package keep_one_in_n_unzip_pkg;

  localparam int SYM_BITS      = 4;
  localparam int SYMS_PER_WORD = 4;
  localparam int LSB_DROP      = 9;
  localparam logic [15:0] ROUND_FILL = 16'h0100;

  // One packed symbol carries an I field and a Q field.
  localparam int SYMBOL_BITS = 2 * SYM_BITS;
  localparam int WORD_BITS   = SYMBOL_BITS * SYMS_PER_WORD;

  typedef logic [1:0] phase_t;
  localparam phase_t PHASE_FIRST = 2'd0;
  localparam phase_t PHASE_LAST  = 2'd3;

  typedef struct packed {
    logic [WORD_BITS-1:0] word;
    logic                 last;
    logic                 full;
  } hold_t;

  // Symbols leave the word most-significant first.
  function automatic logic [SYMBOL_BITS-1:0] sym_select(
    input logic [WORD_BITS-1:0] word,
    input phase_t               phase
  );
    logic [SYMBOL_BITS-1:0] sym;
    case (phase)
      2'd0:    sym = word[31:24];
      2'd1:    sym = word[23:16];
      2'd2:    sym = word[15:8];
      2'd3:    sym = word[7:0];
      default: sym = word[31:24];
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/keep_one_in_n_unzip_expand.sv
// zip_nibble_expand: widens one 4-bit {sign, b2, b1, b0} field to a 16-bit
// sample. The sign is replicated into the top bits, the three magnitude bits
// follow, and the dropped LSBs are zero, or hold the mid-step value when
// round is set. Purely combinational.
// Ports:
//   field  - 4-bit compressed field
//   round  - 1 selects the mid-step fill for the dropped LSBs
//   sample - 16-bit expanded sample
module zip_nibble_expand
  import keep_one_in_n_unzip_pkg::*;
(
  input  logic [SYM_BITS-1:0] field,
  input  logic                round,
  output logic [15:0]         sample
);

  localparam int SIGN_COPIES = 16 - LSB_DROP - (SYM_BITS - 1);

  logic [15:0] base_s;

  assign base_s = {{SIGN_COPIES{field[SYM_BITS-1]}},
                   field[SYM_BITS-2:0],
                   {LSB_DROP{1'b0}}};

  // Rounding only touches bit 8, which is always zero in base_s.
  assign sample = base_s | (round ? ROUND_FILL : 16'h0000);

endmodule

// File: rtl/keep_one_in_n_unzip.sv
// keep_one_in_n_unzip: takes 32-bit words carrying four 8-bit I/Q symbols and
// emits four 32-bit expanded samples per word, first symbol [31:24] first.
// A single holding register plus a 2-bit phase counter sequences the output;
// the next word may be accepted on the cycle its predecessor's last sample
// is taken, so back-to-back words stream with no bubble.
// Parameters:
//   ROUND   - 0: dropped LSBs are zero, 1: dropped LSBs hold 0x100
// Ports:
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset
//   i_tdata  - packed input word, four symbols
//   i_tlast  - packet end, qualified by i_tvalid & i_tready
//   i_tvalid - input word valid
//   i_tready - block accepts the input word
//   o_tdata  - expanded sample, I in [31:16], Q in [15:0]
//   o_tlast  - packet end, only on the last sample of a tlast word
//   o_tvalid - output sample valid
//   o_tready - downstream accepts the sample
module keep_one_in_n_unzip
  import keep_one_in_n_unzip_pkg::*;
#(
  parameter int ROUND = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_BITS-1:0] i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [31:0]          o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready
);

  hold_t  hold_r;
  hold_t  hold_n_s;
  phase_t phase_r;
  phase_t phase_n_s;

  logic                   round_s;
  logic                   in_fire_s;
  logic                   out_fire_s;
  logic                   at_last_s;
  logic [SYMBOL_BITS-1:0] sym_s;

  assign round_s    = (ROUND != 0);
  assign at_last_s  = (phase_r == PHASE_LAST);
  assign out_fire_s = hold_r.full & o_tready;
  // A new word may enter while the final sample of the current one leaves.
  assign i_tready   = ~hold_r.full | (at_last_s & o_tready);
  assign in_fire_s  = i_tvalid & i_tready;

  assign o_tvalid = hold_r.full;
  assign o_tlast  = hold_r.full & hold_r.last & at_last_s;

  // The output path sees only the held word and the phase.
  assign sym_s = sym_select(hold_r.word, phase_r);

  zip_nibble_expand u_expand_i (
    .field  (sym_s[SYMBOL_BITS-1:SYM_BITS]),
    .round  (round_s),
    .sample (o_tdata[31:16])
  );

  zip_nibble_expand u_expand_q (
    .field  (sym_s[SYM_BITS-1:0]),
    .round  (round_s),
    .sample (o_tdata[15:0])
  );

  // Next-state for the holding register and phase counter.
  always_comb begin
    hold_n_s  = hold_r;
    phase_n_s = phase_r;
    if (in_fire_s) begin
      // Also covers the wrap cycle: the old word's last sample leaves now.
      hold_n_s.word = i_tdata;
      hold_n_s.last = i_tlast;
      hold_n_s.full = 1'b1;
      phase_n_s     = PHASE_FIRST;
    end else if (out_fire_s) begin
      phase_n_s = phase_r + 2'd1;
      if (at_last_s) begin
        hold_n_s.full = 1'b0;
      end else begin
        hold_n_s.full = hold_r.full;
      end
    end else begin
      hold_n_s  = hold_r;
      phase_n_s = phase_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_r.word <= 32'h0000_0000;
      hold_r.last <= 1'b0;
      hold_r.full <= 1'b0;
      phase_r     <= PHASE_FIRST;
    end else begin
      hold_r  <= hold_n_s;
      phase_r <= phase_n_s;
    end
  end

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Self-checking bench for keep_one_in_n_unzip. Two instances (ROUND=0 and
// ROUND=1) share the stimulus. Inputs change 1ns after the rising edge and
// outputs are sampled on the falling edge.
module tb_keep_one_in_n_unzip;

  logic        clk;
  logic        reset_n;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        o_tready;

  logic        i_tready0, o_tlast0, o_tvalid0;
  logic [31:0] o_tdata0;
  logic        i_tready1, o_tlast1, o_tvalid1;
  logic [31:0] o_tdata1;

  int n_cmp = 0;
  int n_err = 0;

  keep_one_in_n_unzip #(.ROUND(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready0),
    .o_tdata(o_tdata0), .o_tlast(o_tlast0), .o_tvalid(o_tvalid0), .o_tready(o_tready)
  );

  keep_one_in_n_unzip #(.ROUND(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready1),
    .o_tdata(o_tdata1), .o_tlast(o_tlast1), .o_tvalid(o_tvalid1), .o_tready(o_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Independent expansion model: sign-extended field scaled by 512, plus fill.
  function automatic logic [15:0] model_field(input logic [3:0] f, input bit rnd);
    logic signed [15:0] v;
    v = $signed(f);
    v = v * 16'sd512;
    return v | (rnd ? 16'h0100 : 16'h0000);
  endfunction

  function automatic logic [31:0] model_sample(input logic [7:0] sym, input bit rnd);
    return {model_field(sym[7:4], rnd), model_field(sym[3:0], rnd)};
  endfunction

  // Checks dut0 outputs in the current cycle.
  task automatic expect_out(input string tag, input logic [31:0] d, input logic vld,
                            input logic rdy, input logic lst);
    check_eq({tag, ".data"}, o_tdata0, d);
    check_eq({tag, ".valid"}, 32'(o_tvalid0), 32'(vld));
    check_eq({tag, ".ready"}, 32'(i_tready0), 32'(rdy));
    check_eq({tag, ".last"}, 32'(o_tlast0), 32'(lst));
  endtask

  // Presents one word for a single cycle starting at the next edge.
  task automatic send_word(input logic [31:0] w, input logic l);
    @(posedge clk); #1;
    i_tvalid = 1'b1; i_tdata = w; i_tlast = l;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
  endtask

  // Scoreboard for the throttled run.
  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  bit   sb_en = 1'b0;
  int   exp_last_cnt = 0;
  int   obs_last_cnt = 0;

  // Record accepted words and compare every consumed sample.
  always @(negedge clk) begin
    if (sb_en && reset_n) begin
      if (o_tvalid0 && o_tready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb.unexpected_sample", o_tdata0, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("sb.data0", o_tdata0, e.d0);
          check_eq("sb.data1", o_tdata1, e.d1);
          check_eq("sb.last", 32'(o_tlast0), 32'(e.l));
          if (o_tlast0) obs_last_cnt++;
        end
      end
      if (i_tvalid && i_tready0) begin
        for (int k = 0; k < 4; k++) begin
          exp_t e;
          logic [31:0] w;
          logic [7:0]  sym;
          w   = i_tdata;
          sym = w[31 - 8*k -: 8];
          e.d0 = model_sample(sym, 1'b0);
          e.d1 = model_sample(sym, 1'b1);
          e.l  = (k == 3) && i_tlast;
          exp_q.push_back(e);
        end
        if (i_tlast) exp_last_cnt++;
      end
    end
  end

  logic [31:0] tbl_word [3];
  logic [31:0] tbl_exp  [12];

  initial begin
    int sent;
    int widx;
    int cycles;
    bit acc;

    reset_n  = 1'b0;
    i_tdata  = 32'h0000_0000;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state of both instances.
    @(negedge clk);
    expect_out("reset", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    check_eq("reset.data_round", o_tdata1, 32'h0100_0100);
    check_eq("reset.valid_round", 32'(o_tvalid1), 32'd0);
    check_eq("reset.ready_round", 32'(i_tready1), 32'd1);
    check_eq("reset.last_round", 32'(o_tlast1), 32'd0);

    // Single word, both rounding modes, one sample per cycle.
    o_tready = 1'b1;
    send_word(32'h7F80_00FF, 1'b0);
    @(negedge clk);
    expect_out("w1.s0", 32'h0E00_FE00, 1'b1, 1'b0, 1'b0);
    check_eq("w1.s0_round", o_tdata1, 32'h0F00_FF00);
    @(negedge clk);
    expect_out("w1.s1", 32'hF000_0000, 1'b1, 1'b0, 1'b0);
    check_eq("w1.s1_round", o_tdata1, 32'hF100_0100);
    @(negedge clk);
    expect_out("w1.s2", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check_eq("w1.s2_round", o_tdata1, 32'h0100_0100);
    @(negedge clk);
    expect_out("w1.s3", 32'hFE00_FE00, 1'b1, 1'b1, 1'b0);
    check_eq("w1.s3_round", o_tdata1, 32'hFF00_FF00);
    @(negedge clk);
    check_eq("w1.idle_valid", 32'(o_tvalid0), 32'd0);
    check_eq("w1.idle_ready", 32'(i_tready0), 32'd1);

    // Three back-to-back words, the third closing a packet.
    tbl_word = '{32'h7F80_00FF, 32'h1122_3344, 32'h8899_6677};
    tbl_exp  = '{32'h0E00_FE00, 32'hF000_0000, 32'h0000_0000, 32'hFE00_FE00,
                 32'h0200_0200, 32'h0400_0400, 32'h0600_0600, 32'h0800_0800,
                 32'hF000_F000, 32'hF200_F200, 32'h0C00_0C00, 32'h0E00_0E00};
    @(posedge clk); #1;
    i_tvalid = 1'b1; i_tdata = tbl_word[0]; i_tlast = 1'b0;
    @(posedge clk); #1;
    widx = 1;
    i_tdata = tbl_word[1];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      expect_out($sformatf("b2b.c%0d", c), tbl_exp[c], 1'b1, (c % 4) == 3, c == 11);
      acc = i_tvalid && i_tready0;
      @(posedge clk); #1;
      if (acc) begin
        widx++;
        if (widx < 3) begin
          i_tdata = tbl_word[widx];
          i_tlast = (widx == 2);
        end else begin
          i_tvalid = 1'b0;
          i_tlast  = 1'b0;
        end
      end
    end
    @(negedge clk);
    check_eq("b2b.idle_valid", 32'(o_tvalid0), 32'd0);
    check_eq("b2b.words_taken", 32'(widx), 32'd3);

    // Downstream stall during phase 1.
    send_word(32'h7F80_00FF, 1'b0);
    @(negedge clk);
    expect_out("stall.s0", 32'h0E00_FE00, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    o_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      expect_out($sformatf("stall.hold%0d", c), 32'hF000_0000, 1'b1, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    o_tready = 1'b1;
    @(negedge clk);
    expect_out("stall.s1", 32'hF000_0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("stall.s2", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("stall.s3", 32'hFE00_FE00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("stall.idle_valid", 32'(o_tvalid0), 32'd0);

    // Reset while phase 2 is on the output.
    send_word(32'h7F80_00FF, 1'b1);
    @(negedge clk);
    expect_out("rst.s0", 32'h0E00_FE00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst.s1", 32'hF000_0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst.s2", 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    expect_out("rst.after", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    send_word(32'hFF80_7F00, 1'b0);
    @(negedge clk);
    expect_out("rst.next_s0", 32'hFE00_FE00, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("rst.next_s1", 32'hF000_0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst.next_s3", o_tdata0, 32'h0000_0000);

    // Random throttling on both sides against the scoreboard.
    @(posedge clk); #1;
    sb_en  = 1'b1;
    sent   = 0;
    cycles = 0;
    while ((sent < 1000 || exp_q.size() != 0 || o_tvalid0) && cycles < 30000) begin
      @(negedge clk);
      acc = i_tvalid && i_tready0;
      @(posedge clk); #1;
      cycles++;
      if (acc) begin
        sent++;
        i_tvalid = 1'b0;
      end
      if (!i_tvalid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        i_tvalid = 1'b1;
        i_tdata  = $urandom;
        i_tlast  = ($urandom_range(0, 3) == 0);
      end
      o_tready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    sb_en = 1'b0;
    check_eq("rand.in_budget", 32'(cycles < 30000), 32'd1);
    check_eq("rand.words_sent", 32'(sent), 32'd1000);
    check_eq("rand.queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("rand.tlast_count", 32'(obs_last_cnt), 32'(exp_last_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
